// File: rtl/rob_unit_if.sv
// Reorder-buffer port bundle: dispatch, execute writeback, mispredict,
// operand lookup and commit.
//   master : the surrounding pipeline (drives dispatch/WB/mispredict/lookup
//            indices, observes ready/index/lookup results/commit)
//   slave  : rob_unit
interface rob_unit_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned RD_W   = 6;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 32;

  // Dispatch / allocation
  logic              dispatch_valid;
  logic [RD_W-1:0]   dispatch_rd;
  logic [PC_W-1:0]   dispatch_pc;
  logic              dispatch_ready;
  logic [IDX_W-1:0]  dispatch_rob_idx;

  // Execute-stage writeback (no backpressure)
  logic              WB_out_valid;
  logic [IDX_W-1:0]  WB_out_rob_idx;
  logic [DATA_W-1:0] WB_out_data;

  // Branch mispredict truncation
  logic              mispredict;
  logic [IDX_W-1:0]  mis_rob_idx;

  // Operand lookup, two read ports
  logic [IDX_W-1:0]  lkp_idx_a;
  logic [IDX_W-1:0]  lkp_idx_b;
  logic              lkp_ready_a;
  logic              lkp_ready_b;
  logic [DATA_W-1:0] lkp_data_a;
  logic [DATA_W-1:0] lkp_data_b;

  // In-order retire
  logic              commit_valid;
  logic [RD_W-1:0]   commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [PC_W-1:0]   commit_pc;
  logic [IDX_W-1:0]  commit_rob_idx;

  modport master (
    output dispatch_valid, dispatch_rd, dispatch_pc,
    input  dispatch_ready, dispatch_rob_idx,
    output WB_out_valid, WB_out_rob_idx, WB_out_data,
    output mispredict, mis_rob_idx,
    output lkp_idx_a, lkp_idx_b,
    input  lkp_ready_a, lkp_ready_b, lkp_data_a, lkp_data_b,
    input  commit_valid, commit_rd, commit_data, commit_pc, commit_rob_idx
  );

  modport slave (
    input  dispatch_valid, dispatch_rd, dispatch_pc,
    output dispatch_ready, dispatch_rob_idx,
    input  WB_out_valid, WB_out_rob_idx, WB_out_data,
    input  mispredict, mis_rob_idx,
    input  lkp_idx_a, lkp_idx_b,
    output lkp_ready_a, lkp_ready_b, lkp_data_a, lkp_data_b,
    output commit_valid, commit_rd, commit_data, commit_pc, commit_rob_idx
  );
endinterface

// File: rtl/rob_unit.sv
// Eight-entry reorder buffer. Allocates one entry per dispatched instruction,
// absorbs one writeback per cycle, retires completed entries in program order
// and truncates younger entries on a branch mispredict.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   rob  : rob_unit_if.slave bundle (dispatch, writeback, mispredict,
//          lookup, commit); all outputs are combinational from registered
//          state, lookup additionally from the same-cycle writeback inputs.
module rob_unit #(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  rob_unit_if.slave rob
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned RD_W   = 6;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 32;

  // Entry storage
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Pointers carry a wrap bit above the index
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [IDX_W-1:0]  head_idx, tail_idx;

  logic              full;
  logic              do_dispatch;
  logic              do_commit;
  logic              do_flush;
  logic [IDX_W-1:0]  mis_off;

  logic [DEPTH-1:0]  alloc_hit;
  logic [DEPTH-1:0]  wb_hit;
  logic [DEPTH-1:0]  retire_hit;
  logic [DEPTH-1:0]  flush_hit;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Same index with differing wrap bits means every slot is occupied
  assign full = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Dispatch looks only at registered fullness, so a same-cycle retire
  // never opens a slot for the instruction dispatched in that cycle.
  assign do_dispatch = rob.dispatch_valid && !full && !rob.mispredict;
  assign do_commit   = valid_q[head_idx] && done_q[head_idx];
  assign do_flush    = rob.mispredict && valid_q[rob.mis_rob_idx];

  // Age of the mispredicted branch relative to the oldest entry
  assign mis_off = IDX_W'(rob.mis_rob_idx - head_idx);

  // Pointer update
  always_comb begin : next_ptrs
    head_d = head_q;
    tail_d = tail_q;
    if (do_commit) begin
      head_d = head_q + PTR_W'(1);
    end
    // Rebuilding tail from the old head keeps the wrap bit consistent with
    // the surviving occupancy; a same-cycle commit moves head and so
    // reduces that occupancy by one on its own.
    if (do_flush) begin
      tail_d = head_q + PTR_W'(mis_off) + PTR_W'(1);
    end else if (do_dispatch) begin
      tail_d = tail_q + PTR_W'(1);
    end
  end

  // Per-entry update strobes
  always_comb begin : entry_hits
    alloc_hit  = '0;
    wb_hit     = '0;
    retire_hit = '0;
    flush_hit  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_hit[i]  = do_dispatch && (tail_idx == IDX_W'(i));
      wb_hit[i]     = rob.WB_out_valid && valid_q[i]
                      && (rob.WB_out_rob_idx == IDX_W'(i));
      retire_hit[i] = do_commit && (head_idx == IDX_W'(i));
      // Anything older-than-or-equal to the branch survives; entries past
      // the tail are already invalid, so clearing them too is harmless.
      flush_hit[i]  = do_flush && (IDX_W'(IDX_W'(i) - head_idx) > mis_off);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
          rd_q[i]    <= rob.dispatch_rd;
          pc_q[i]    <= rob.dispatch_pc;
        end
        if (wb_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= rob.WB_out_data;
        end
        if (retire_hit[i] || flush_hit[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Allocation status
  assign rob.dispatch_ready   = !full;
  assign rob.dispatch_rob_idx = tail_idx;

  // Head retire; payload held at zero when nothing retires
  always_comb begin : commit_out
    rob.commit_valid   = do_commit;
    rob.commit_rd      = '0;
    rob.commit_data    = '0;
    rob.commit_pc      = '0;
    rob.commit_rob_idx = '0;
    if (do_commit) begin
      rob.commit_rd      = rd_q[head_idx];
      rob.commit_data    = data_q[head_idx];
      rob.commit_pc      = pc_q[head_idx];
      rob.commit_rob_idx = head_idx;
    end
  end

  // Operand lookup with same-cycle writeback forwarding
  always_comb begin : lookup
    rob.lkp_ready_a = 1'b0;
    rob.lkp_data_a  = '0;
    rob.lkp_ready_b = 1'b0;
    rob.lkp_data_b  = '0;
    if (valid_q[rob.lkp_idx_a]) begin
      if (rob.WB_out_valid && (rob.WB_out_rob_idx == rob.lkp_idx_a)) begin
        rob.lkp_ready_a = 1'b1;
        rob.lkp_data_a  = rob.WB_out_data;
      end else begin
        rob.lkp_ready_a = done_q[rob.lkp_idx_a];
        rob.lkp_data_a  = data_q[rob.lkp_idx_a];
      end
    end
    if (valid_q[rob.lkp_idx_b]) begin
      if (rob.WB_out_valid && (rob.WB_out_rob_idx == rob.lkp_idx_b)) begin
        rob.lkp_ready_b = 1'b1;
        rob.lkp_data_b  = rob.WB_out_data;
      end else begin
        rob.lkp_ready_b = done_q[rob.lkp_idx_b];
        rob.lkp_data_b  = data_q[rob.lkp_idx_b];
      end
    end
  end

endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit: a commit scoreboard filled at dispatch
// time and drained by a commit monitor, plus per-scenario inline checks.
module tb_rob_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rob_unit_if #(.DEPTH(8)) bus ();

  rob_unit #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [5:0]  rd;
    logic [15:0] pc;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_data [8];
  logic [7:0]  m_done;
  int          m_tail;
  int          checks   = 0;
  int          failures = 0;

  sb_t         mon_exp;
  logic [56:0] mon_act;
  logic [56:0] mon_expv;

  // Commit monitor: every retire must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (bus.commit_valid === 1'b1) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL commit_spurious: got idx=%0d pc=%h, expected no commit",
                   bus.commit_rob_idx, bus.commit_pc);
        end else begin
          mon_exp  = sb.pop_front();
          mon_act  = {bus.commit_rob_idx, bus.commit_rd, bus.commit_pc, bus.commit_data};
          mon_expv = {mon_exp.idx, mon_exp.rd, mon_exp.pc, exp_data[mon_exp.idx]};
          if (mon_act !== mon_expv) begin
            failures++;
            $display("FAIL commit_entry: got idx/rd/pc/data=%h, expected %h",
                     mon_act, mon_expv);
          end
        end
      end else begin
        mon_act = {bus.commit_rob_idx, bus.commit_rd, bus.commit_pc, bus.commit_data};
        if (bus.commit_valid !== 1'b0 || mon_act !== 57'd0) begin
          failures++;
          $display("FAIL commit_idle: got valid=%b fields=%h, expected 0/0",
                   bus.commit_valid, mon_act);
        end
      end
    end
  end

  task automatic idle();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_rd    = '0;
    bus.dispatch_pc    = '0;
    bus.WB_out_valid   = 1'b0;
    bus.WB_out_rob_idx = '0;
    bus.WB_out_data    = '0;
    bus.mispredict     = 1'b0;
    bus.mis_rob_idx    = '0;
    bus.lkp_idx_a      = '0;
    bus.lkp_idx_b      = '0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    advance();
    advance();
    rst = 1'b0;
    sb.delete();
    m_tail = 0;
    m_done = '0;
  endtask

  // Drive a dispatch the bench knows will be accepted
  task automatic set_dispatch(input logic [5:0] rd, input logic [15:0] pc);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_rd    = rd;
    bus.dispatch_pc    = pc;
    sb.push_back('{idx: 3'(m_tail), rd: rd, pc: pc});
    m_done[m_tail] = 1'b0;
    m_tail = (m_tail + 1) % 8;
  endtask

  // Drive a writeback to a live entry and record its expected result
  task automatic wb(input logic [2:0] idx, input logic [31:0] data);
    bus.WB_out_valid   = 1'b1;
    bus.WB_out_rob_idx = idx;
    bus.WB_out_data    = data;
    exp_data[idx]      = data;
    m_done[idx]        = 1'b1;
  endtask

  // Complete every outstanding entry, then wait for the retires
  task automatic drain();
    logic [2:0] idxs[$];
    foreach (sb[i]) if (!m_done[sb[i].idx]) idxs.push_back(sb[i].idx);
    foreach (idxs[i]) begin
      idle();
      wb(idxs[i], 32'hC0DE_0000 | 32'($urandom_range(0, 16'hFFFF)));
      advance();
    end
    idle();
    for (int n = 0; n < 30 && sb.size() != 0; n++) advance();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_dispatch: got ready=%b idx=%0d, expected 1/0",
               bus.dispatch_ready, bus.dispatch_rob_idx);
    end
    checks++;
    if ({bus.lkp_ready_a, bus.lkp_data_a, bus.lkp_ready_b, bus.lkp_data_b} !== 66'd0) begin
      failures++;
      $display("FAIL reset_lookup: got ra=%b da=%h rb=%b db=%h, expected zeros",
               bus.lkp_ready_a, bus.lkp_data_a, bus.lkp_ready_b, bus.lkp_data_b);
    end
    advance();
    // Reset in the middle of traffic discards all entries
    for (int i = 0; i < 3; i++) begin
      idle();
      set_dispatch(6'(i + 1), 16'(16'h0040 + 4 * i));
      advance();
    end
    idle();
    wb(3'd0, 32'h1234_5678);
    advance();
    idle();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    sb.delete();
    m_tail = 0;
    m_done = '0;
    bus.lkp_idx_a = 3'd0;
    settle();
    checks++;
    if (bus.dispatch_rob_idx !== 3'd0 || bus.commit_valid !== 1'b0 ||
        bus.lkp_ready_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_midrun: got idx=%0d commit=%b lkp=%b, expected 0/0/0",
               bus.dispatch_rob_idx, bus.commit_valid, bus.lkp_ready_a);
    end
    advance();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      set_dispatch(6'(i + 1), 16'(4 * i));
      settle();
      checks++;
      if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 3'(i)) begin
        failures++;
        $display("FAIL fill_alloc: got ready=%b idx=%0d, expected 1/%0d",
                 bus.dispatch_ready, bus.dispatch_rob_idx, i);
      end
      advance();
    end
    // Ninth dispatch while full must be ignored
    idle();
    bus.dispatch_valid = 1'b1;
    bus.dispatch_rd    = 6'd9;
    bus.dispatch_pc    = 16'h0020;
    settle();
    checks++;
    if (bus.dispatch_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got ready=%b, expected 0", bus.dispatch_ready);
    end
    advance();
    idle();
    settle();
    checks++;
    if (bus.dispatch_ready !== 1'b0 || bus.dispatch_rob_idx !== 3'd0) begin
      failures++;
      $display("FAIL fill_ignored: got ready=%b idx=%0d, expected 0/0",
               bus.dispatch_ready, bus.dispatch_rob_idx);
    end
    advance();
  endtask

  // Runs on the full buffer left by test_fill
  task automatic test_out_of_order();
    logic [2:0]  wb_idx [3];
    logic [31:0] wb_dat [3];
    wb_idx = '{3'd2, 3'd0, 3'd1};
    wb_dat = '{32'h22, 32'h00, 32'h11};
    for (int k = 0; k < 3; k++) begin
      idle();
      wb(wb_idx[k], wb_dat[k]);
      settle();
      checks++;
      if (bus.commit_valid !== (k == 2)) begin
        failures++;
        $display("FAIL ooo_hold: step %0d got commit=%b, expected %b",
                 k, bus.commit_valid, (k == 2));
      end
      advance();
    end
    for (int k = 1; k < 4; k++) begin
      idle();
      settle();
      checks++;
      if (bus.commit_valid !== (k < 3) || (k < 3 && bus.commit_rob_idx !== 3'(k))) begin
        failures++;
        $display("FAIL ooo_order: got commit=%b idx=%0d, expected %b/%0d",
                 bus.commit_valid, bus.commit_rob_idx, (k < 3), k);
      end
      advance();
    end
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL ooo_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      set_dispatch(6'(i + 8), 16'(16'h0100 + 4 * i));
      advance();
    end
    idle();
    bus.mispredict     = 1'b1;
    bus.mis_rob_idx    = 3'd2;
    bus.dispatch_valid = 1'b1;
    bus.dispatch_pc    = 16'h0DEA;
    advance();
    m_tail = 3;
    while (sb.size() > 0 && sb[$].idx != 3'd2) void'(sb.pop_back());
    idle();
    settle();
    checks++;
    if (bus.dispatch_rob_idx !== 3'd3 || bus.dispatch_ready !== 1'b1) begin
      failures++;
      $display("FAIL mis_tail: got idx=%0d ready=%b, expected 3/1",
               bus.dispatch_rob_idx, bus.dispatch_ready);
    end
    advance();
    // Writeback to a flushed entry is dropped
    idle();
    bus.WB_out_valid   = 1'b1;
    bus.WB_out_rob_idx = 3'd4;
    bus.WB_out_data    = 32'h4444_4444;
    bus.lkp_idx_a      = 3'd4;
    settle();
    checks++;
    if (bus.lkp_ready_a !== 1'b0 || bus.lkp_data_a !== 32'd0) begin
      failures++;
      $display("FAIL mis_flushed_lkp: got ready=%b data=%h, expected 0/0",
               bus.lkp_ready_a, bus.lkp_data_a);
    end
    advance();
    drain();
    checks++;
    if (sb.size() != 0 || bus.commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_drain: got left=%0d commit=%b, expected 0/0",
               sb.size(), bus.commit_valid);
    end
  endtask

  task automatic test_full_commit_dispatch();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      set_dispatch(6'(i + 32), 16'(16'h0200 + 4 * i));
      advance();
    end
    idle();
    wb(3'd0, 32'h0000_00A0);
    advance();
    idle();
    bus.dispatch_valid = 1'b1;
    bus.dispatch_pc    = 16'h0BAD;
    settle();
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 3'd0 ||
        bus.dispatch_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_retire: got commit=%b idx=%0d ready=%b, expected 1/0/0",
               bus.commit_valid, bus.commit_rob_idx, bus.dispatch_ready);
    end
    advance();
    idle();
    settle();
    checks++;
    if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 3'd0) begin
      failures++;
      $display("FAIL full_freed: got ready=%b idx=%0d, expected 1/0",
               bus.dispatch_ready, bus.dispatch_rob_idx);
    end
    set_dispatch(6'd5, 16'h0300);
    advance();
    idle();
    settle();
    checks++;
    if (bus.dispatch_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refill: got ready=%b, expected 0", bus.dispatch_ready);
    end
    advance();
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL full_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_lookup_forward();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      set_dispatch(6'(i + 16), 16'(16'h0500 + 4 * i));
      advance();
    end
    idle();
    bus.lkp_idx_a = 3'd3;
    settle();
    checks++;
    if (bus.lkp_ready_a !== 1'b0) begin
      failures++;
      $display("FAIL lkp_pending: got ready=%b, expected 0", bus.lkp_ready_a);
    end
    advance();
    idle();
    wb(3'd3, 32'hDEAD_BEEF);
    bus.lkp_idx_a = 3'd3;
    bus.lkp_idx_b = 3'd5;
    settle();
    checks++;
    if (bus.lkp_ready_a !== 1'b1 || bus.lkp_data_a !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lkp_forward: got ready=%b data=%h, expected 1/deadbeef",
               bus.lkp_ready_a, bus.lkp_data_a);
    end
    checks++;
    if (bus.lkp_ready_b !== 1'b0 || bus.lkp_data_b !== 32'd0) begin
      failures++;
      $display("FAIL lkp_invalid: got ready=%b data=%h, expected 0/0",
               bus.lkp_ready_b, bus.lkp_data_b);
    end
    advance();
    idle();
    bus.lkp_idx_b = 3'd3;
    settle();
    checks++;
    if (bus.lkp_ready_b !== 1'b1 || bus.lkp_data_b !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lkp_stored: got ready=%b data=%h, expected 1/deadbeef",
               bus.lkp_ready_b, bus.lkp_data_b);
    end
    advance();
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL lkp_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      idle();
      set_dispatch(6'(k + 1), 16'(16'h0400 + 4 * k));
      if (k > 0) wb(3'((k - 1) % 8), 32'h5000_0000 + 32'(k));
      settle();
      checks++;
      if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 3'(k % 8)) begin
        failures++;
        $display("FAIL wrap_alloc: cycle %0d got ready=%b idx=%0d, expected 1/%0d",
                 k, bus.dispatch_ready, bus.dispatch_rob_idx, k % 8);
      end
      if (k >= 2) begin
        checks++;
        if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 3'((k - 2) % 8)) begin
          failures++;
          $display("FAIL wrap_commit: cycle %0d got commit=%b idx=%0d, expected 1/%0d",
                   k, bus.commit_valid, bus.commit_rob_idx, (k - 2) % 8);
        end
      end
      advance();
    end
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_tail = 0;
    m_done = '0;
    for (int i = 0; i < 8; i++) exp_data[i] = '0;
    test_reset();
    test_fill();
    test_out_of_order();
    test_mispredict();
    test_full_commit_dispatch();
    test_lookup_forward();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
